// File: rtl/ahfp_pkg.sv
// Shared constants and stage records for the ahfp normaliser pipeline.
// AHFP_NORM_ROUND_EN adds a guard bit to the S2 record for round-to-nearest.
package ahfp_pkg;

    localparam int EXP_W     = 8;
    localparam int FRAC_W    = 23;
    localparam int RAW_MAN_W = 26;
    localparam int LZC_W     = 5;

    localparam logic [EXP_W-1:0] EXP_MAX    = 8'hFF;
    localparam logic [31:0]      FP_ZERO    = 32'h0000_0000;
    localparam logic [30:0]      FP_INF_MAG = 31'h7F80_0000;

    // S1 -> S2: raw operand plus leading-zero analysis; carry bit kept as a flag.
    typedef struct packed {
        logic                   sign;
        logic [EXP_W-1:0]       exp;
        logic [RAW_MAN_W-2:0]   man;
        logic [LZC_W-1:0]       lz;
        logic                   carry;
        logic                   zero;
    } s1_rec_t;

    // S2 -> S3: normalised fraction with 9-bit exponent so overflow is visible.
    typedef struct packed {
        logic                   sign;
        logic [EXP_W:0]         exp;
        logic [FRAC_W-1:0]      frac;
`ifdef AHFP_NORM_ROUND_EN
        logic                   guard;
`endif
        logic                   flush;
    } s2_rec_t;

endpackage

// File: rtl/ahfp_lzd.sv
// Combinational leading-zero detector; an all-zero input reports IN_W zeros.
module ahfp_lzd #(
    parameter int IN_W = 25,
    parameter int LZ_W = 5
) (
    input  logic [IN_W-1:0] data_i,
    output logic [LZ_W-1:0] lz_o,
    output logic            zero_o
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        lz_o   = LZ_W'(IN_W);
        zero_o = (data_i == '0);
        for (int i = 0; i < IN_W; i++) begin
            if (data_i[i]) begin
                lz_o = LZ_W'(IN_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/ahfp_norm_pipe.sv
// Three-stage post-add normaliser: LZD, normalising shift, IEEE-754 pack.
// Define AHFP_NORM_ROUND_EN for round-to-nearest (ties away); default truncates.
module ahfp_norm_pipe
    import ahfp_pkg::*;
#(
    parameter int MAN_W = RAW_MAN_W,
    parameter int LZ_W  = LZC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [7:0]       in_exp,
    input  logic [MAN_W-1:0] in_man,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result
);

    logic        s1_valid_q;
    logic        s2_valid_q;
    logic        out_valid_q;
    s1_rec_t     s1_q, s1_d;
    s2_rec_t     s2_q, s2_d;
    logic [31:0] out_result_q, result_d;

    logic        ld1, ld2, ld3;
    logic [LZ_W-1:0] lzd_count;
    logic        lzd_zero;

    // A stage may load when empty or when its own word is leaving this cycle.
    assign ld3 = !out_valid_q | out_ready;
    assign ld2 = !s2_valid_q  | ld3;
    assign ld1 = !s1_valid_q  | ld2;

    assign in_ready   = ld1;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;

    ahfp_lzd #(
        .IN_W (MAN_W-1),
        .LZ_W (LZ_W)
    ) u_lzd (
        .data_i (in_man[MAN_W-2:0]),
        .lz_o   (lzd_count),
        .zero_o (lzd_zero)
    );

    always_comb begin
        s1_d       = '0;
        s1_d.sign  = in_sign;
        s1_d.exp   = in_exp;
        s1_d.man   = in_man[MAN_W-2:0];
        s1_d.lz    = lzd_count;
        s1_d.carry = in_man[MAN_W-1];
        s1_d.zero  = lzd_zero & !in_man[MAN_W-1];
    end

    logic [EXP_W:0] exp9, lz9;

`ifdef AHFP_NORM_ROUND_EN
    logic [FRAC_W:0] fg_carry, fg_shift;
    assign fg_carry = s1_q.man[24:1];
    assign fg_shift = 24'(s1_q.man[23:0] << s1_q.lz);
`endif

    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        exp9      = {1'b0, s1_q.exp};
        lz9       = 9'(s1_q.lz);
        if (s1_q.carry) begin
            s2_d.exp = exp9 + 9'd1;
`ifdef AHFP_NORM_ROUND_EN
            {s2_d.frac, s2_d.guard} = fg_carry;
`else
            s2_d.frac = s1_q.man[24:2];
`endif
        end else if (s1_q.zero || (exp9 <= lz9)) begin
            // Result would be zero or denormal: flush instead.
            s2_d.flush = 1'b1;
        end else begin
            s2_d.exp = exp9 - lz9;
`ifdef AHFP_NORM_ROUND_EN
            {s2_d.frac, s2_d.guard} = fg_shift;
`else
            s2_d.frac = 23'((s1_q.man[23:0] << s1_q.lz) >> 1);
`endif
        end
    end

    logic [EXP_W:0]    exp_w;
    logic [FRAC_W-1:0] frac_w;

    always_comb begin
        exp_w  = s2_q.exp;
        frac_w = s2_q.frac;
`ifdef AHFP_NORM_ROUND_EN
        if (s2_q.guard) begin
            if (&s2_q.frac) begin
                frac_w = '0;
                exp_w  = s2_q.exp + 9'd1;
            end else begin
                frac_w = s2_q.frac + 23'd1;
            end
        end
`endif
        if (s2_q.flush) begin
            result_d = FP_ZERO;
        end else if (exp_w >= {1'b0, EXP_MAX}) begin
            result_d = {s2_q.sign, FP_INF_MAG};
        end else begin
            result_d = {s2_q.sign, exp_w[EXP_W-1:0], frac_w};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= FP_ZERO;
            s1_q         <= '0;
            s2_q         <= '0;
        end else begin
            if (ld1) begin
                s1_valid_q <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (ld2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) s2_q <= s2_d;
            end
            if (ld3) begin
                out_valid_q <= s2_valid_q;
                if (s2_valid_q) out_result_q <= result_d;
            end
        end
    end

endmodule

// File: tb/tb_ahfp_norm_pipe.sv
// Bench for ahfp_norm_pipe: directed vectors, backpressure, reset flush, random traffic.
module tb_ahfp_norm_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [25:0] in_man;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    bit mon_en    = 0;
    bit rnd_ready = 0;

    always #5 clk = ~clk;

    ahfp_norm_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_man     (in_man),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    // Reference: place the leading one at the hidden-bit position arithmetically.
    function automatic logic [31:0] ref_model(input logic s, input logic [7:0] e8, input logic [25:0] m);
        int p, e, frac;
        longint mm;
`ifdef AHFP_NORM_ROUND_EN
        int g;
`endif
        if (m == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 26; i++) if (m[i]) p = i;
        e = int'(e8) - 24 + p;
        if (e <= 0) return 32'h0;
        if (p == 25) mm = longint'(m >> 1);
        else         mm = longint'(m) << (24 - p);
        frac = int'((mm >> 1) & 64'h7FFFFF);
`ifdef AHFP_NORM_ROUND_EN
        g = int'(mm & 64'h1);
        if (g == 1) begin
            frac = frac + 1;
            if (frac == 'h800000) begin
                frac = 0;
                e    = e + 1;
            end
        end
`endif
        if (e >= 255) return {s, 8'hFF, 23'h0};
        return {s, e[7:0], frac[22:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic s, input logic [7:0] e, input logic [25:0] m);
        bit done = 0;
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_man   = m;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                if (mon_en) exp_q.push_back(ref_model(s, e, m));
            end
            tick();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1 within 200 cycles", in_ready);
        end
    endtask

    task automatic monitor();
        logic        prev_stall = 1'b0;
        logic [31:0] prev_res   = 32'h0;
        logic [31:0] want;
        forever begin
            @(negedge clk);
            if (reset || !mon_en) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_result !== prev_res) begin
                        errors++;
                        $display("FAIL hold_stable: valid=%b result=%h, required valid=1 result=%h",
                                 out_valid, out_result, prev_res);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: result=%h, required no output", out_result);
                    end else begin
                        want = exp_q.pop_front();
                        if (out_result !== want) begin
                            errors++;
                            $display("FAIL stream_result: got %h, required %h", out_result, want);
                        end else begin
                            $display("txn ok result=%h", out_result);
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_res   = out_result;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'h0; in_man = 26'h0; out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++;
        if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result: got %h, required 00000000", out_result); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        $display("txn reset done");
        tick();
    endtask

    task automatic test_directed();
        logic        vs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0]  ve[7]  = '{8'h81, 8'h80, 8'h80, 8'h90, 8'h05, 8'hFE, 8'h7F};
        logic [25:0] vm[7]  = '{26'h1800000, 26'h3400000, 26'h0000200, 26'h0,
                                26'h0000200, 26'h2000000, 26'h1FFFFFF};
`ifdef AHFP_NORM_ROUND_EN
        logic [31:0] vr[7]  = '{32'h40C00000, 32'h40D00000, 32'h38800000, 32'h0,
                                32'h0, 32'hFF800000, 32'h40000000};
`else
        logic [31:0] vr[7]  = '{32'h40C00000, 32'h40D00000, 32'h38800000, 32'h0,
                                32'h0, 32'hFF800000, 32'h3FFFFFFF};
`endif
        int lat;
        bit seen;
        mon_en = 0; rnd_ready = 0; out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            send(vs[k], ve[k], vm[k]);
            in_valid = 1'b0;
            seen = 0;
            lat  = 0;
            for (int n = 1; n <= 10 && !seen; n++) begin
                @(negedge clk);
                if (out_valid) begin seen = 1; lat = n; end
            end
            checks++;
            if (lat != 3) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, required 3", k, lat);
            end
            checks++;
            if (out_result !== vr[k]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got %h, required %h", k, out_result, vr[k]);
            end else begin
                $display("txn directed[%0d] exp=%h man=%h result=%h", k, ve[k], vm[k], out_result);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        mon_en = 1; rnd_ready = 0; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(1'($urandom), 8'($urandom_range(30, 200)), 26'($urandom));
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, required 0 with 3 held", in_ready); end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b, required 1", out_valid); end
        repeat (2) tick();
        out_ready = 1'b1;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: %0d words left, required 0", exp_q.size()); end
        $display("txn backpressure drained");
    endtask

    task automatic test_reset_inflight();
        int stray = 0;
        mon_en = 1; rnd_ready = 0; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(1'b0, 8'h90, 26'($urandom));
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL inflight_pre: out_valid=%b, required 1", out_valid); end
        mon_en = 0;
        exp_q.delete();
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL inflight_reset_valid: got %b, required 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL inflight_reset_ready: got %b, required 1", in_ready); end
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (out_valid) stray++;
            tick();
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL inflight_discard: %0d stray outputs, required 0", stray); end
        $display("txn reset in flight done");
    endtask

    task automatic test_random();
        logic [25:0] m;
        logic [7:0]  e;
        mon_en = 1; rnd_ready = 1;
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 4))
                0:       m = {1'b1, 25'($urandom)};
                1:       m = {2'b01, 24'($urandom)};
                2:       m = 26'($urandom) >> $urandom_range(0, 25);
                3:       m = 26'h0;
                default: m = 26'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       e = 8'hFF;
                1:       e = 8'hFE;
                2:       e = 8'($urandom_range(0, 24));
                default: e = 8'($urandom);
            endcase
            send(1'($urandom), e, m);
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b0;
        rnd_ready = 0;
        out_ready = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL random_drain: %0d words left, required 0", exp_q.size()); end
        mon_en = 0;
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
